// File: rtl/text_display_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// text_display_engine
//
// Text-mode LCD display engine. Generates LCD raster timing from the pixel
// clock, fetches character/attribute words from an external synchronous VRAM,
// looks up glyph rows in an external synchronous font ROM and emits one 4-bit
// IRGB colour per pixel. Sync, data-enable and colour leave on the same clock.
// Supports integer pixel replication, attribute blink and a blinking hardware
// cursor.
//
// Ports
//   clk_i         pixel clock, the only clock
//   rst_i         asynchronous active-high reset
//   vram_addr_o   cell word address (row_base + text column)
//   vram_data_i   {blink, bg RGB[2:0], fg IRGB[3:0], char[7:0]}, 1 clock late
//   font_addr_o   {char[7:0], glyph_line[2:0]}
//   font_data_i   glyph row, bit7 = leftmost pixel, 1 clock after font_addr_o
//   cursor_en_i   cursor enable
//   cursor_col_i  cursor text column
//   cursor_row_i  cursor text row
//   lcd_hsync_o   horizontal sync, active level SYNC_POL
//   lcd_vsync_o   vertical sync, active level SYNC_POL
//   lcd_den_o     data enable (visible pixel)
//   color_o       IRGB pixel colour, 0 outside the visible area
//   vblank_o      high while the line counter is outside the visible area
//
// Pipeline (counter state to pins = 3 clocks):
//   S0  counters address the VRAM
//   S1  VRAM word arrives; its character indexes the font ROM
//   S2  glyph row arrives; colour is resolved into the output registers
// -----------------------------------------------------------------------------
module text_display_engine #(
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 2,
    parameter int H_SYNC     = 41,
    parameter int H_BP       = 2,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 2,
    parameter int V_SYNC     = 10,
    parameter int V_BP       = 2,
    parameter int SCALE_LOG2 = 1,
    parameter int VRAM_AW    = 10,
    parameter bit SYNC_POL   = 1'b0,
    parameter int BLINK_LOG2 = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    input  logic [15:0]        vram_data_i,
    output logic [10:0]        font_addr_o,
    input  logic [7:0]         font_data_i,
    input  logic               cursor_en_i,
    input  logic [6:0]         cursor_col_i,
    input  logic [5:0]         cursor_row_i,
    output logic               lcd_hsync_o,
    output logic               lcd_vsync_o,
    output logic               lcd_den_o,
    output logic [3:0]         color_o,
    output logic               vblank_o
);

    // -------------------------------------------------------------------------
    // Geometry
    // -------------------------------------------------------------------------
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CELL_LOG2 = 3 + SCALE_LOG2;
    localparam int CELL_PX   = 1 << CELL_LOG2;
    localparam int COLS      = H_ACTIVE >> CELL_LOG2;
    localparam int ROWS      = V_ACTIVE >> CELL_LOG2;

    // One spare bit so that every window boundary (up to H_TOTAL) is
    // representable and comparisons never wrap.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [VRAM_AW-1:0] COLS_W = VRAM_AW'(COLS);

    // The visible area must tile exactly into cells; the frame counter needs
    // at least two bits to provide separate blink and cursor phases.
    if ((H_ACTIVE % CELL_PX) != 0 || (V_ACTIVE % CELL_PX) != 0 ||
        COLS < 1 || ROWS < 1) begin : g_bad_geometry
        $error("text_display_engine: active area is not a whole number of cells");
    end
    if (BLINK_LOG2 < 2) begin : g_bad_blink
        $error("text_display_engine: BLINK_LOG2 must be at least 2");
    end

    // -------------------------------------------------------------------------
    // S0: raster counters, row base and frame counter
    // -------------------------------------------------------------------------
    logic [HW-1:0]         hcnt_reg;
    logic [VW-1:0]         vcnt_reg;
    logic [VRAM_AW-1:0]    row_base_reg;
    logic [BLINK_LOG2-1:0] frame_reg;

    logic h_wrap;
    logic v_wrap;
    logic row_end;

    assign h_wrap  = (hcnt_reg == H_LAST);
    assign v_wrap  = (vcnt_reg == V_LAST);
    // Last scanline of a text row: all glyph-line and replication bits set.
    assign row_end = &vcnt_reg[CELL_LOG2-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt_reg     <= '0;
            vcnt_reg     <= '0;
            row_base_reg <= '0;
            frame_reg    <= '0;
        end else if (h_wrap) begin
            hcnt_reg <= '0;
            if (v_wrap) begin
                vcnt_reg     <= '0;
                row_base_reg <= '0;
                frame_reg    <= frame_reg + BLINK_LOG2'(1);
            end else begin
                vcnt_reg <= vcnt_reg + VW'(1);
                // Row base walks in steps of COLS so the address is a plain
                // add of the text column, with no multiplier.
                if (row_end) begin
                    row_base_reg <= row_base_reg + COLS_W;
                end
            end
        end else begin
            hcnt_reg <= hcnt_reg + HW'(1);
        end
    end

    logic [15:0] text_col;
    logic [15:0] text_row;

    assign text_col    = 16'(hcnt_reg >> CELL_LOG2);
    assign text_row    = 16'(vcnt_reg >> CELL_LOG2);
    assign vram_addr_o = row_base_reg + VRAM_AW'(text_col);

    // -------------------------------------------------------------------------
    // Per-pixel control carried alongside the memory fetches. Syncs are held
    // as "asserted" flags so that a zero pipeline means inactive sync for
    // either polarity; polarity is applied at the output register.
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       vblank;
        logic       blink_ph;
        logic       cur_inv;
        logic [2:0] cell_x;
    } ctrl_t;

    ctrl_t      ctrl_next;
    ctrl_t      s1_reg;
    ctrl_t      s2_reg;
    logic [2:0] glyph_next;
    logic [2:0] s1_glyph_reg;
    logic [7:0] s2_attr_reg;
    logic       cursor_hit;

    always_comb begin
        glyph_next = vcnt_reg[SCALE_LOG2 +: 3];

        // Cursor occupies only the bottom glyph line of its cell.
        cursor_hit = cursor_en_i &&
                     (text_col == {9'd0, cursor_col_i}) &&
                     (text_row == {10'd0, cursor_row_i}) &&
                     (glyph_next == 3'd7);

        ctrl_next          = '0;
        ctrl_next.active   = (hcnt_reg < H_ACT) && (vcnt_reg < V_ACT);
        ctrl_next.hsync    = (hcnt_reg >= HS_START) && (hcnt_reg < HS_END);
        ctrl_next.vsync    = (vcnt_reg >= VS_START) && (vcnt_reg < VS_END);
        ctrl_next.vblank   = (vcnt_reg >= V_ACT);
        ctrl_next.blink_ph = frame_reg[BLINK_LOG2-1];
        ctrl_next.cur_inv  = cursor_hit & frame_reg[BLINK_LOG2-2];
        ctrl_next.cell_x   = hcnt_reg[SCALE_LOG2 +: 3];
    end

    // -------------------------------------------------------------------------
    // S1 / S2 pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_reg       <= '0;
            s1_glyph_reg <= '0;
            s2_reg       <= '0;
            s2_attr_reg  <= '0;
        end else begin
            s1_reg       <= ctrl_next;
            s1_glyph_reg <= glyph_next;
            s2_reg       <= s1_reg;
            // Attribute byte arrives with the VRAM word during S1.
            s2_attr_reg  <= vram_data_i[15:8];
        end
    end

    // The font ROM is addressed straight from the VRAM word so that its row
    // is back in time for S2. Held at zero outside the visible area.
    assign font_addr_o = s1_reg.active ? {vram_data_i[7:0], s1_glyph_reg} : 11'd0;

    // -------------------------------------------------------------------------
    // S2: pixel resolve
    // -------------------------------------------------------------------------
    // Bit-reversed glyph row so cell_x indexes directly (bit7 = leftmost).
    logic [7:0] glyph_rev;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_glyph_rev
            assign glyph_rev[gi] = font_data_i[7-gi];
        end
    endgenerate

    logic       font_bit;
    logic       blink_off;
    logic       pix_on;
    logic [3:0] color_next;

    always_comb begin
        font_bit  = glyph_rev[s2_reg.cell_x];
        // Blinking cells show background only during the low blink phase.
        blink_off = s2_attr_reg[7] & ~s2_reg.blink_ph;
        pix_on    = (font_bit & ~blink_off) ^ s2_reg.cur_inv;

        color_next = 4'd0;
        if (s2_reg.active) begin
            color_next = pix_on ? s2_attr_reg[3:0] : {1'b0, s2_attr_reg[6:4]};
        end
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    logic       hsync_reg;
    logic       vsync_reg;
    logic       den_reg;
    logic [3:0] color_reg;
    logic       vblank_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_reg  <= ~SYNC_POL;
            vsync_reg  <= ~SYNC_POL;
            den_reg    <= 1'b0;
            color_reg  <= 4'd0;
            vblank_reg <= 1'b0;
        end else begin
            hsync_reg  <= s2_reg.hsync ? SYNC_POL : ~SYNC_POL;
            vsync_reg  <= s2_reg.vsync ? SYNC_POL : ~SYNC_POL;
            den_reg    <= s2_reg.active;
            color_reg  <= color_next;
            vblank_reg <= s2_reg.vblank;
        end
    end

    assign lcd_hsync_o = hsync_reg;
    assign lcd_vsync_o = vsync_reg;
    assign lcd_den_o   = den_reg;
    assign color_o     = color_reg;
    assign vblank_o    = vblank_reg;

endmodule

// File: tb/tb_text_display_engine.sv
`timescale 1ns/1ps
// Bench for text_display_engine using a reduced raster:
//   H: 48 visible + 2 FP + 4 sync + 2 BP = 56 clocks per line
//   V: 32 visible + 1 FP + 2 sync + 1 BP = 36 lines per frame (2016 clocks)
//   16x16 cells (SCALE_LOG2=1) -> 3 columns x 2 rows
//   BLINK_LOG2=3: blink phase = frame[2], cursor phase = frame[1]
module tb_text_display_engine;

    localparam int HT = 56;
    localparam int VT = 36;
    localparam int FT = HT * VT;

    logic        clk;
    logic        rst;
    logic [9:0]  vram_addr;
    logic [15:0] vram_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        hsync;
    logic        vsync;
    logic        den;
    logic [3:0]  color;
    logic        vblank;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_cnt;

    logic [15:0] vram [0:1023];
    logic [7:0]  font [0:2047];

    text_display_engine #(
        .H_ACTIVE(48), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE_LOG2(1), .VRAM_AW(10), .SYNC_POL(1'b0), .BLINK_LOG2(3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .vram_addr_o  (vram_addr),
        .vram_data_i  (vram_data),
        .font_addr_o  (font_addr),
        .font_data_i  (font_data),
        .cursor_en_i  (cursor_en),
        .cursor_col_i (cursor_col),
        .cursor_row_i (cursor_row),
        .lcd_hsync_o  (hsync),
        .lcd_vsync_o  (vsync),
        .lcd_den_o    (den),
        .color_o      (color),
        .vblank_o     (vblank)
    );

    always #5 clk = ~clk;

    // Synchronous memories with one clock of read latency.
    always @(posedge clk) begin
        vram_data <= vram[vram_addr];
        font_data <= font[font_addr];
    end

    // Rising edges since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    // Park on the falling edge that follows rising edge number 'target'.
    task automatic wait_edge(input int target);
        int guard = 0;
        while (edge_cnt < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (edge_cnt != target) begin
            n_fail++;
            $display("FAIL wait_edge actual_edge=%0d required_edge=%0d", edge_cnt, target);
        end
    endtask

    // Output edge for counter state (frame, line, pixel): three clocks late.
    function automatic int pix_edge(input int f, input int v, input int h);
        return f * FT + v * HT + h + 3;
    endfunction

    task automatic init_memories();
        logic [7:0] glyph_a [8];
        glyph_a = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
        for (int i = 0; i < 1024; i++) vram[i] = 16'h0000;
        for (int i = 0; i < 2048; i++) font[i] = 8'h00;
        for (int l = 0; l < 8; l++) begin
            font[8'h41 * 8 + l] = glyph_a[l];
            font[8'h55 * 8 + l] = 8'hF0;
            font[8'h81 * 8 + l] = 8'hAA;
        end
        vram[0] = 16'h1F41;   // 'A', fg F, bg 1
        vram[1] = 16'h8741;   // blinking 'A', fg 7, bg 0
        vram[2] = 16'hF900;   // space, bg 7 (intensity never set on bg)
        vram[3] = 16'h2A55;   // 0x55 -> F0 rows, fg A, bg 2
        vram[4] = 16'h0700;   // space, fg 7, bg 0 (cursor cell)
        vram[5] = 16'h4C81;   // 0x81 -> AA rows, fg C, bg 4
    endtask

    task automatic test_reset();
        // Held in reset from time zero.
        n_cmp++; if (den !== 1'b0)      begin n_fail++; $display("FAIL por_den actual=%b required=0", den); end
        n_cmp++; if (color !== 4'h0)    begin n_fail++; $display("FAIL por_color actual=%h required=0", color); end
        n_cmp++; if (hsync !== 1'b1)    begin n_fail++; $display("FAIL por_hsync actual=%b required=1", hsync); end
        n_cmp++; if (vsync !== 1'b1)    begin n_fail++; $display("FAIL por_vsync actual=%b required=1", vsync); end
        n_cmp++; if (vblank !== 1'b0)   begin n_fail++; $display("FAIL por_vblank actual=%b required=0", vblank); end
        n_cmp++; if (font_addr !== 11'd0) begin n_fail++; $display("FAIL por_font_addr actual=%h required=0", font_addr); end
        $display("reset: power-on values checked");
        rst = 1'b0;

        // Mid-line, mid-glyph pixel (line 5, pixel 10) is foreground F.
        wait_edge(pix_edge(0, 5, 10));
        n_cmp++; if (den !== 1'b1)   begin n_fail++; $display("FAIL pre_rst_den actual=%b required=1", den); end
        n_cmp++; if (color !== 4'hF) begin n_fail++; $display("FAIL pre_rst_color actual=%h required=F", color); end

        rst = 1'b1;
        #1;
        n_cmp++; if (den !== 1'b0)      begin n_fail++; $display("FAIL rst_den actual=%b required=0", den); end
        n_cmp++; if (color !== 4'h0)    begin n_fail++; $display("FAIL rst_color actual=%h required=0", color); end
        n_cmp++; if (hsync !== 1'b1)    begin n_fail++; $display("FAIL rst_hsync actual=%b required=1", hsync); end
        n_cmp++; if (vsync !== 1'b1)    begin n_fail++; $display("FAIL rst_vsync actual=%b required=1", vsync); end
        n_cmp++; if (vblank !== 1'b0)   begin n_fail++; $display("FAIL rst_vblank actual=%b required=0", vblank); end
        n_cmp++; if (font_addr !== 11'd0) begin n_fail++; $display("FAIL rst_font_addr actual=%h required=0", font_addr); end
        n_cmp++; if (vram_addr !== 10'd0) begin n_fail++; $display("FAIL rst_vram_addr actual=%h required=0", vram_addr); end
        $display("reset: mid-line reset values checked");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        wait_edge(1);
        n_cmp++; if (den !== 1'b0) begin n_fail++; $display("FAIL den_edge1 actual=%b required=0", den); end
        wait_edge(2);
        n_cmp++; if (den !== 1'b0) begin n_fail++; $display("FAIL den_edge2 actual=%b required=0", den); end
        wait_edge(3);
        n_cmp++; if (den !== 1'b1)   begin n_fail++; $display("FAIL den_edge3 actual=%b required=1", den); end
        n_cmp++; if (color !== 4'h1) begin n_fail++; $display("FAIL pixel00 actual=%h required=1", color); end
        $display("reset: first pixel after release checked");
    endtask

    task automatic test_fetch();
        int         vv [13] = '{0, 0, 2, 2, 2, 8, 8, 20, 20, 20, 20, 20, 30};
        int         hh [13] = '{4, 6, 0, 6, 40, 12, 14, 0, 10, 32, 34, 48, 20};
        logic [3:0] ex [13] = '{4'h1, 4'hF, 4'h1, 4'hF, 4'h7, 4'hF, 4'h1,
                                4'hA, 4'h2, 4'hC, 4'h4, 4'h0, 4'h0};
        for (int i = 0; i < 13; i++) begin
            wait_edge(pix_edge(0, vv[i], hh[i]));
            n_cmp++;
            if (color !== ex[i]) begin
                n_fail++;
                $display("FAIL fetch_color v=%0d h=%0d actual=%h required=%h", vv[i], hh[i], color, ex[i]);
            end
            $display("fetch: v=%0d h=%0d color=%h", vv[i], hh[i], color);
        end
    endtask

    task automatic test_addr();
        // kind 0: vram_addr for the current counter state
        // kind 1: font_addr for the previous counter state
        int          kk [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
        int          vv [10] = '{0, 0, 0, 0, 2, 15, 16, 20, 20, 31};
        int          hh [10] = '{0, 16, 40, 50, 6, 47, 0, 0, 20, 47};
        logic [10:0] ex [10] = '{11'd0, 11'd1, 11'd2, 11'h000, 11'h209,
                                 11'd2, 11'd3, 11'h2AA, 11'd4, 11'd5};
        logic [10:0] obs;
        for (int i = 0; i < 10; i++) begin
            wait_edge(FT + vv[i] * HT + hh[i] + kk[i]);
            obs = (kk[i] == 0) ? {1'b0, vram_addr} : font_addr;
            n_cmp++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL addr kind=%0d v=%0d h=%0d actual=%h required=%h", kk[i], vv[i], hh[i], obs, ex[i]);
            end
            $display("addr: kind=%0d v=%0d h=%0d value=%h", kk[i], vv[i], hh[i], obs);
        end
    endtask

    task automatic test_timing();
        int hs_low = 0, vs_low = 0, den_hi = 0, vb_hi = 0;
        // sel 0 den, 1 hsync, 2 vsync, 3 vblank
        int   vv [14] = '{0, 0, 0, 0, 0, 0, 31, 31, 32, 32, 33, 34, 35, 35};
        int   hh [14] = '{47, 48, 49, 50, 53, 54, 0, 0, 0, 0, 0, 55, 0, 55};
        int   ss [14] = '{0, 0, 1, 1, 1, 1, 3, 2, 3, 0, 2, 2, 2, 3};
        logic ex [14] = '{1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1};
        logic obs;

        wait_edge(2 * FT);
        for (int i = 1; i <= FT; i++) begin
            wait_edge(2 * FT + i);
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (den === 1'b1)   den_hi++;
            if (vblank === 1'b1) vb_hi++;
        end
        n_cmp++; if (hs_low != 144)  begin n_fail++; $display("FAIL hsync_low_count actual=%0d required=144", hs_low); end
        n_cmp++; if (vs_low != 112)  begin n_fail++; $display("FAIL vsync_low_count actual=%0d required=112", vs_low); end
        n_cmp++; if (den_hi != 1536) begin n_fail++; $display("FAIL den_high_count actual=%0d required=1536", den_hi); end
        n_cmp++; if (vb_hi != 224)   begin n_fail++; $display("FAIL vblank_count actual=%0d required=224", vb_hi); end
        $display("timing: frame counts hs=%0d vs=%0d den=%0d vb=%0d", hs_low, vs_low, den_hi, vb_hi);

        for (int i = 0; i < 14; i++) begin
            wait_edge(pix_edge(3, vv[i], hh[i]));
            case (ss[i])
                0:       obs = den;
                1:       obs = hsync;
                2:       obs = vsync;
                default: obs = vblank;
            endcase
            n_cmp++;
            if (obs !== ex[i]) begin
                n_fail++;
                $display("FAIL align sel=%0d v=%0d h=%0d actual=%b required=%b", ss[i], vv[i], hh[i], obs, ex[i]);
            end
            $display("timing: sel=%0d v=%0d h=%0d value=%b", ss[i], vv[i], hh[i], obs);
        end
    endtask

    task automatic test_blink();
        int         ff [6] = '{4, 4, 7, 8, 11, 12};
        int         hh [6] = '{16, 22, 22, 22, 22, 22};
        logic [3:0] ex [6] = '{4'h0, 4'h7, 4'h7, 4'h0, 4'h0, 4'h7};
        for (int i = 0; i < 6; i++) begin
            wait_edge(pix_edge(ff[i], 2, hh[i]));
            n_cmp++;
            if (color !== ex[i]) begin
                n_fail++;
                $display("FAIL blink frame=%0d h=%0d actual=%h required=%h", ff[i], hh[i], color, ex[i]);
            end
            $display("blink: frame=%0d h=%0d color=%h", ff[i], hh[i], color);
        end
    endtask

    task automatic test_cursor();
        int         ff [12] = '{13, 14, 14, 14, 14, 14, 14, 15, 15, 15, 18, 18};
        int         vv [12] = '{30, 29, 30, 30, 30, 31, 31, 30, 30, 30, 30, 30};
        int         hh [12] = '{20, 20, 15, 16, 20, 31, 32, 0, 10, 20, 0, 20};
        logic [3:0] ex [12] = '{4'h0, 4'h0, 4'h2, 4'h7, 4'h7, 4'h7, 4'hC,
                                4'h2, 4'hA, 4'h0, 4'hA, 4'h0};
        for (int i = 0; i < 12; i++) begin
            wait_edge(pix_edge(ff[i], vv[i], hh[i]));
            n_cmp++;
            if (color !== ex[i]) begin
                n_fail++;
                $display("FAIL cursor frame=%0d v=%0d h=%0d actual=%h required=%h", ff[i], vv[i], hh[i], color, ex[i]);
            end
            $display("cursor: frame=%0d v=%0d h=%0d color=%h", ff[i], vv[i], hh[i], color);
            // Move the cursor onto the glyph cell, then switch it off.
            if (i == 6) begin
                cursor_col = 7'd0;
                cursor_row = 6'd1;
            end
            if (i == 9) cursor_en = 1'b0;
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        cursor_en  = 1'b1;
        cursor_col = 7'd1;
        cursor_row = 6'd1;
        init_memories();
        repeat (4) @(negedge clk);
        test_reset();
        test_fetch();
        test_addr();
        test_timing();
        test_blink();
        test_cursor();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
